// File: rtl/serial_add4_pkg.sv
// serial_add4_pkg: shared state encoding, default width and sizing helper
// for the bit-serial adder.
package serial_add4_pkg;

    // Default operand/result width.
    localparam int ADD_WIDTH = 4;

    // Controller states. The fourth encoding is unused and recovers to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-step counter width. It only has to reach WIDTH-1 and never wraps.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add4_fulladd.sv
// fulladd: one-bit full adder built from two half-adder cells; the carry
// out is the OR of both half-adder carries (they can never both be high).
module fulladd (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    logic s0;
    logic c0;
    logic c1;

    // First stage adds the two operand bits.
    halfadd u_ha0 (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (s0),
        .carry_o (c0)
    );

    // Second stage folds in the incoming carry.
    halfadd u_ha1 (
        .a_i     (s0),
        .b_i     (c_i),
        .sum_o   (sum_o),
        .carry_o (c1)
    );

    assign carry_o = c0 | c1;

endmodule

// File: rtl/serial_add4_halfadd.sv
// halfadd: one-bit half adder cell (sum and carry of two bits).
module halfadd (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

// File: rtl/serial_add4.sv
// serial_add4: bit-serial adder. Operands and carry-in are captured on the
// accepting edge, then added LSB-first one bit per clock through a single
// full adder. The running carry sits in a flop and result bits shift into
// r_sh from the top, so after WIDTH steps r_sh holds the full sum.
// Outputs are all registered; no input reaches an output combinationally.
module serial_add4
    import serial_add4_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Elaboration guard: a one-bit serial adder is not a supported build.
    if (WIDTH < 2) begin : g_width_check
        $error("serial_add4: WIDTH must be at least 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic [WIDTH-1:0] r_sh_q,  r_sh_d;
    logic             c_q,     c_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_step;

    // The one and only adder stage, fed from the operand LSBs and carry flop.
    fulladd u_fulladd (
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .c_i     (c_q),
        .sum_o   (fa_sum),
        .carry_o (fa_carry)
    );

    assign last_step = (cnt_q == CNT_LAST);

    // Next-state and datapath: accept in idle, one bit step per run cycle,
    // publish the result on the final step, then a single done cycle.
    always_comb begin
        // NOTE: every _d is given its hold value first so that no branch
        // leaves a signal unassigned; that is what keeps this block free of
        // inferred latches.
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    c_d     = cin_i;
                    cnt_d   = '0;
                    r_sh_d  = '0;
                end
            end

            ST_RUN: begin
                r_sh_d = {fa_sum, r_sh_q[WIDTH-1:1]};
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                c_d    = fa_carry;
                if (last_step) begin
                    // Counter holds at WIDTH-1 rather than wrapping.
                    state_d = ST_DONE;
                    sum_d   = r_sh_d;
                    cout_d  = fa_carry;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is written only with non-blocking '<=' so
        // every flop samples the pre-edge values, regardless of statement order.
        if (rst_i) begin
            // NOTE: the shift registers and carry are cleared along with the
            // control state, so an aborted operation leaves no stale bits.
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
